provocador: RTL and testbench



---
 rtl/provocador_pkg.sv | 24 ++
 rtl/generador_fase.sv | 45 ++++
 rtl/provocador.sv | 117 +++++++++++
 tb/tb_provocador.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/provocador_pkg.sv
// Shared definitions for the setup-time stimulus generator: timing defaults,
// FSM state encoding and the expected-verdict function.
package provocador_pkg;

    localparam int unsigned TICK_NS_DEF = 5;
    localparam int unsigned TSU_NS_DEF  = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // True when a D change placed 'off' ticks ahead of the clock edge lands
    // inside the setup window. Exactly tsu_ns of lead is still legal.
    function automatic logic viola_setup(input logic [15:0] off,
                                         input logic [15:0] tick_ns,
                                         input logic [15:0] tsu_ns);
        logic [31:0] lead_ns;
        lead_ns = 32'(off) * 32'(tick_ns);
        return lead_ns < 32'(tsu_ns);
    endfunction

endpackage

// File: rtl/generador_fase.sv
// Phase counter for the divided flip-flop clock. Produces the registered
// CLK_FF and two look-ahead strobes (next-cycle rise, next-cycle launch) so
// the parent can update D_FF on the very same edge that moves CLK_FF.
module generador_fase #(
    parameter int DIV   = 16,
    parameter int OFF_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [OFF_W-1:0] cur_off,
    output logic             clk_ff,
    output logic             rise,
    output logic             launch
);

    localparam int PH_W = $clog2(DIV);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_next;
    logic [PH_W-1:0] launch_phase;

    // Next phase and the strobes decoded from it.
    always_comb begin
        phase_next   = (phase == PH_W'(DIV - 1)) ? '0 : phase + PH_W'(1);
        // cur_off never exceeds DIV/2, so DIV - cur_off stays in range except
        // for cur_off = 0, which folds onto the rising edge itself.
        launch_phase = (cur_off == '0) ? '0 : PH_W'(DIV - int'(cur_off));
        rise         = (phase_next == '0);
        launch       = (phase_next == launch_phase);
    end

    // Phase register and 50% duty CLK_FF, restarted high from phase 0.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (RESET) begin
            phase  <= '0;
            clk_ff <= 1'b1;
        end else begin
            phase  <= phase_next;
            clk_ff <= (phase_next < PH_W'(DIV / 2));
        end
    end

endmodule

// File: rtl/provocador.sv
// Setup-time stimulus generator: drives CLK_FF/D_FF with D changes placed a
// programmed number of ticks before each CLK_FF rise, and reports the verdict
// a correct setup checker should give for every counted edge.
module provocador
    import provocador_pkg::*;
#(
    parameter int DIV     = 16,
    parameter int OFF_W   = 4,
    parameter int TICK_NS = TICK_NS_DEF,
    parameter int TSU_NS  = TSU_NS_DEF,
    parameter int NEDGES  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SWEEP,
    input  logic [OFF_W-1:0] OFFSET,
    output logic             CLK_FF,
    output logic             D_FF,
    output logic             EXP_ALARM,
    output logic             BUSY,
    output logic             DONE
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(NEDGES + HALF + 2);

    state_t           state, state_n;
    logic             sweep, sweep_n;
    logic [OFF_W-1:0] cur_off, cur_off_n, off_sat;
    logic [CNT_W-1:0] edge_cnt, edge_cnt_n;
    logic             d_n, alarm_n, done_n, last_edge;
    logic             rise, launch;

    generador_fase #(
        .DIV   (DIV),
        .OFF_W (OFF_W)
    ) u_fase (
        .CLK     (CLK),
        .RESET   (RESET),
        .cur_off (cur_off),
        .clk_ff  (CLK_FF),
        .rise    (rise),
        .launch  (launch)
    );

    // Offsets above DIV/2 would move the D change into the CLK_FF high phase.
    assign off_sat = (OFFSET > OFF_W'(HALF)) ? OFF_W'(HALF) : OFFSET;

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_n    = state;
        sweep_n    = sweep;
        cur_off_n  = cur_off;
        edge_cnt_n = edge_cnt;
        d_n        = D_FF;
        alarm_n    = EXP_ALARM;
        done_n     = 1'b0;
        last_edge  = sweep ? (cur_off == '0) : (edge_cnt == CNT_W'(NEDGES - 1));

        case (state)
            IDLE: begin
                if (START) begin
                    sweep_n    = SWEEP;
                    cur_off_n  = SWEEP ? OFF_W'(HALF) : off_sat;
                    edge_cnt_n = '0;
                    alarm_n    = 1'b0;
                    state_n    = ARM;
                end
            end
            ARM: begin
                // The first rise only aligns the run; nothing is launched for it.
                if (rise) state_n = RUN;
            end
            RUN: begin
                if (launch) d_n = ~D_FF;
                if (rise) begin
                    alarm_n    = viola_setup(16'(cur_off), 16'(TICK_NS), 16'(TSU_NS));
                    edge_cnt_n = edge_cnt + CNT_W'(1);
                    if (last_edge) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else if (sweep) begin
                        cur_off_n = cur_off - OFF_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over any request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            sweep     <= 1'b0;
            cur_off   <= '0;
            edge_cnt  <= '0;
            D_FF      <= 1'b0;
            EXP_ALARM <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_n;
            sweep     <= sweep_n;
            cur_off   <= cur_off_n;
            edge_cnt  <= edge_cnt_n;
            D_FF      <= d_n;
            EXP_ALARM <= alarm_n;
            BUSY      <= (state_n != IDLE);
            DONE      <= done_n;
        end
    end

endmodule

// File: tb/tb_provocador.sv
// Directed bench for provocador: table of single/sweep runs with
// hand-computed per-edge lead times and verdicts, plus reset corner cases.
module tb_provocador;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic       SWEEP;
    logic [3:0] OFFSET;
    logic       CLK_FF, D_FF, EXP_ALARM, BUSY, DONE;

    int n_cmp = 0;
    int n_bad = 0;

    provocador dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SWEEP     (SWEEP),
        .OFFSET    (OFFSET),
        .CLK_FF    (CLK_FF),
        .D_FF      (D_FF),
        .EXP_ALARM (EXP_ALARM),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // One run request with its expected outcome. Nibble k of offs is the
    // expected D-to-CLK_FF lead of counted edge k; bit k of alarms its verdict.
    typedef struct {
        string      name;
        logic       sweep;
        logic [3:0] offset;
        logic       start_mid;
        int         n_edges;
        logic [35:0] offs;
        logic [8:0]  alarms;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_case(input vec_t v);
        int   k, dones, tog_cyc;
        bit   pending, finished;
        logic prev_clk, prev_d;
        k = 0; dones = 0; tog_cyc = 0; pending = 0; finished = 0;
        START = 1'b1; SWEEP = v.sweep; OFFSET = v.offset;
        prev_clk = CLK_FF; prev_d = D_FF;
        tick();
        START = 1'b0;
        prev_clk = CLK_FF; prev_d = D_FF;
        check({v.name, " alarm cleared on arm"}, EXP_ALARM, 0);
        check({v.name, " busy after start"}, BUSY, 1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (v.start_mid && cyc == 20) begin
                START = 1'b1; SWEEP = 1'b1; OFFSET = 4'd0;
            end else begin
                START = 1'b0;
            end
            tick();
            if (D_FF !== prev_d) begin
                pending = 1;
                tog_cyc = cyc;
            end
            if (CLK_FF && !prev_clk && pending) begin
                if (k < 9) begin
                    check($sformatf("%s lead edge %0d", v.name, k), cyc - tog_cyc,
                          int'(v.offs[k*4 +: 4]));
                    check($sformatf("%s alarm edge %0d", v.name, k), EXP_ALARM,
                          int'(v.alarms[k]));
                    check($sformatf("%s done edge %0d", v.name, k), DONE,
                          (k == v.n_edges - 1) ? 1 : 0);
                end
                k++;
                pending = 0;
            end
            if (DONE) begin
                dones++;
                finished = 1;
            end
            prev_clk = CLK_FF; prev_d = D_FF;
        end
        START = 1'b0; SWEEP = 1'b0; OFFSET = 4'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE) dones++;
        end
        check({v.name, " counted edges"}, k, v.n_edges);
        check({v.name, " done pulses"}, dones, 1);
        check({v.name, " busy after run"}, BUSY, 0);
    endtask

    initial begin
        int   highs, rises, r1, f1, r2, k, dones, busies, first_low, tog_cyc;
        bit   pending;
        logic prev_clk, prev_d;

        vecs[0] = '{"single off8",  1'b0, 4'd8,  1'b0, 4, 36'h000008888, 9'b000000000};
        vecs[1] = '{"single off6",  1'b0, 4'd6,  1'b0, 4, 36'h000006666, 9'b000000000};
        vecs[2] = '{"single off5",  1'b0, 4'd5,  1'b0, 4, 36'h000005555, 9'b000001111};
        vecs[3] = '{"sweep",        1'b1, 4'd3,  1'b0, 9, 36'h012345678, 9'b111111000};
        vecs[4] = '{"single off15", 1'b0, 4'd15, 1'b1, 4, 36'h000008888, 9'b000000000};
        vecs[5] = '{"single off0",  1'b0, 4'd0,  1'b0, 4, 36'h000000000, 9'b000001111};

        // Reset values and idle behaviour.
        RESET = 1'b1; START = 1'b0; SWEEP = 1'b0; OFFSET = 4'd0;
        tick(); tick();
        check("reset CLK_FF", CLK_FF, 1);
        check("reset D_FF", D_FF, 0);
        check("reset EXP_ALARM", EXP_ALARM, 0);
        check("reset BUSY", BUSY, 0);
        check("reset DONE", DONE, 0);
        RESET = 1'b0;
        highs = 0; rises = 0; r1 = -1; f1 = -1; r2 = -1; busies = 0;
        prev_clk = CLK_FF;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (CLK_FF) highs++;
            if (CLK_FF && !prev_clk) begin
                rises++;
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            if (!CLK_FF && prev_clk && r1 >= 0 && f1 < 0) f1 = i;
            if (D_FF || BUSY || EXP_ALARM || DONE) busies++;
            prev_clk = CLK_FF;
        end
        check("idle high ticks", highs, 32);
        check("idle rises", rises, 4);
        check("idle high width", f1 - r1, 8);
        check("idle period", r2 - r1, 16);
        check("idle outputs quiet", busies, 0);

        // Table-driven runs.
        for (int i = 0; i < 6; i++) run_case(vecs[i]);

        // RESET at the second counted edge of a sweep.
        START = 1'b1; SWEEP = 1'b1; OFFSET = 4'd8;
        tick();
        START = 1'b0;
        prev_clk = CLK_FF; prev_d = D_FF; k = 0; pending = 0; tog_cyc = 0;
        for (int cyc = 0; cyc < 200 && k < 2; cyc++) begin
            tick();
            if (D_FF !== prev_d) begin pending = 1; tog_cyc = cyc; end
            if (CLK_FF && !prev_clk && pending) begin k++; pending = 0; end
            prev_clk = CLK_FF; prev_d = D_FF;
        end
        check("mid-sweep reached 2nd edge", k, 2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid reset CLK_FF", CLK_FF, 1);
        check("mid reset D_FF", D_FF, 0);
        check("mid reset EXP_ALARM", EXP_ALARM, 0);
        check("mid reset BUSY", BUSY, 0);
        check("mid reset DONE", DONE, 0);
        dones = 0; busies = 0; first_low = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (DONE) dones++;
            if (BUSY) busies++;
            if (!CLK_FF && first_low < 0) first_low = i;
        end
        check("mid reset no done", dones, 0);
        check("mid reset stays idle", busies, 0);
        check("mid reset phase restart", first_low, 8);

        // START together with RESET: reset wins.
        START = 1'b1; SWEEP = 1'b0; OFFSET = 4'd4; RESET = 1'b1;
        tick();
        START = 1'b0; RESET = 1'b0;
        tick();
        check("start with reset ignored", BUSY, 0);

        // A fresh run after the reset behaves normally.
        run_case(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
